// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter (8N1, LSB first) with a small
// TX FIFO and a pollable status register.
// Register map (word index): 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit before the stop bit
// and reports parity support in STATUS bit7.
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_WIDTH    = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic       PARITY_SUP = 1'b1;
`else
    localparam logic       PARITY_SUP = 1'b0;
`endif

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;

    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]       CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]       CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(2);

    logic [7:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count, count_nxt;
    logic                 fifo_full, fifo_empty;
    logic                 push_req, push, pop;
    logic                 overflow;
    logic [DIV_WIDTH-1:0] divisor;

    logic [2:0]           state_q, state_nxt;
    logic [DIV_WIDTH-1:0] timer_q, timer_nxt;
    logic [DIV_WIDTH-1:0] div_lat_q, div_lat_nxt;
    logic [2:0]           bit_idx_q, bit_idx_nxt;
    logic [7:0]           shift_q, shift_nxt;
    logic                 tx_nxt;
    logic                 tx_busy_nxt;
    logic [31:0]          count_ext;
    logic [2:0]           cnt_sat;

    // Upper write-data bits are never consumed by any register.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:DIV_WIDTH];

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign push_req   = sel && we && (addr == A_DATA);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    // A full FIFO still accepts a byte when the FSM frees an entry that cycle.
    assign push       = push_req && (!fifo_full || pop);

    assign count_ext  = 32'(count);
    assign cnt_sat    = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

    // Next FIFO occupancy, also used to register tx_busy with the state.
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_ONE;
        else if (pop && !push)
            count_nxt = count - CNT_ONE;
    end

    // FIFO storage; contents are only read when count says they are valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata[7:0];
    end

    // FIFO pointers, occupancy, sticky overflow and the divisor register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            divisor  <= DIV_WIDTH'(CLKS_PER_BIT);
        end else begin
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
            else if (sel && we && (addr == A_STATUS)) overflow <= 1'b0;
            if (sel && we && (addr == A_DIV) && (wdata[DIV_WIDTH-1:0] >= DIV_MIN))
                divisor <= wdata[DIV_WIDTH-1:0];
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_q;
    // Even parity of the byte being sent, captured when it leaves the FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  parity_q <= 1'b0;
        else if (pop)  parity_q <= ^mem[rd_ptr];
    end
`endif

    // Frame sequencer: tx is registered and updated together with the state,
    // so the line changes exactly on state-transition edges.
    always_comb begin
        state_nxt   = state_q;
        timer_nxt   = timer_q;
        div_lat_nxt = div_lat_q;
        bit_idx_nxt = bit_idx_q;
        shift_nxt   = shift_q;
        tx_nxt      = tx;
        case (state_q)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (pop) begin
                    shift_nxt   = mem[rd_ptr];
                    div_lat_nxt = divisor;
                    timer_nxt   = divisor - DIV_ONE;
                    state_nxt   = S_START;
                    tx_nxt      = 1'b0;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    state_nxt   = S_DATA;
                    bit_idx_nxt = 3'd0;
                    timer_nxt   = div_lat_q - DIV_ONE;
                    tx_nxt      = shift_q[0];
                end else begin
                    timer_nxt = timer_q - DIV_ONE;
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_nxt = div_lat_q - DIV_ONE;
                    shift_nxt = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
                        tx_nxt    = parity_q;
`else
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx_q + 3'd1;
                        tx_nxt      = shift_q[1];
                    end
                end else begin
                    timer_nxt = timer_q - DIV_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (timer_q == '0) begin
                    state_nxt = S_STOP;
                    timer_nxt = div_lat_q - DIV_ONE;
                    tx_nxt    = 1'b1;
                end else begin
                    timer_nxt = timer_q - DIV_ONE;
                end
            end
`endif
            S_STOP: begin
                tx_nxt = 1'b1;
                if (timer_q == '0) state_nxt = S_IDLE;
                else               timer_nxt = timer_q - DIV_ONE;
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    assign tx_busy_nxt = (state_nxt != S_IDLE) || (count_nxt != '0);

    // Sequencer registers; reset aborts any frame and idles the line at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            div_lat_q <= DIV_WIDTH'(CLKS_PER_BIT);
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            timer_q   <= timer_nxt;
            div_lat_q <= div_lat_nxt;
            bit_idx_q <= bit_idx_nxt;
            shift_q   <= shift_nxt;
            tx        <= tx_nxt;
            tx_busy   <= tx_busy_nxt;
        end
    end

    // Registered read port; rdata holds between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (sel && !we) begin
            case (addr)
                A_STATUS: rdata <= {24'b0, PARITY_SUP, overflow, cnt_sat,
                                    fifo_empty, fifo_full, tx_busy};
                A_DIV:    rdata <= 32'(divisor);
                default:  rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed, self-checking bench for mmio_uart_tx.
// Register accesses come from a vector table; the line traffic is recorded
// cycle by cycle and compared to a trace built from the bytes and divisors.
module tb_mmio_uart_tx;

    localparam int DIV0 = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PBIT  = 32'h80;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PBIT  = 32'h00;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel     = 1'b0;
    logic        we      = 1'b0;
    logic [1:0]  addr    = 2'd0;
    logic [31:0] wdata   = 32'd0;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit rec_en   = 1'b0;
    bit rec_q[$];
    bit exp_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    mmio_uart_tx #(.CLKS_PER_BIT(DIV0), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (rec_en) rec_q.push_back(tx);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        sel = 1'b1; we = 1'b0; addr = a;
        tick();
        sel = 1'b0;
        check(name, rdata, exp);
    endtask

    task automatic wait_idle(input int max, input string name);
        int c = 0;
        while (tx_busy !== 1'b0 && c < max) begin
            tick();
            c++;
        end
        check(name, {31'b0, tx_busy}, 32'd0);
    endtask

    // Expected line samples for one frame, optionally preceded by the single
    // idle cycle that separates back-to-back frames.
    task automatic add_frame(input logic [7:0] b, input int div, input bit gap);
        bit bits[$];
        if (gap) exp_q.push_back(1'b1);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < div; k++) exp_q.push_back(bits[i]);
    endtask

    task automatic compare_trace(input string name);
        int s = 0;
        int bad = -1;
        while (s < rec_q.size() && rec_q[s] == 1'b1) s++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (s + i >= rec_q.size() || rec_q[s+i] != exp_q[i]) begin
                bad = i;
                break;
            end
        end
        if (bad < 0)
            for (int j = s + exp_q.size(); j < rec_q.size(); j++)
                if (rec_q[j] != 1'b1) begin
                    bad = j - s;
                    break;
                end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: line differs from required frame trace at sample %0d (recorded %0d samples, required %0d)",
                     name, bad, rec_q.size() - s, exp_q.size());
        end
    endtask

    task automatic send_one(input logic [7:0] b, input string name);
        rec_q.delete(); exp_q.delete();
        rec_en = 1'b1;
        wr(2'd0, {24'hFFFFFF, b});
        wait_idle(NBITS * DIV0 + 20, {name, "_idle"});
        tick();
        rec_en = 1'b0;
        add_frame(b, DIV0, 1'b0);
        compare_trace(name);
    endtask

    initial begin
        bit ok;

        vecs[0]  = '{1'b0, 2'd2, 32'h0,        1'b1, 32'd4};
        vecs[1]  = '{1'b0, 2'd3, 32'h0,        1'b1, 32'd0};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,        1'b1, 32'd0};
        vecs[3]  = '{1'b0, 2'd1, 32'h0,        1'b1, 32'h04 | PBIT};
        vecs[4]  = '{1'b1, 2'd2, 32'd1,        1'b0, 32'd0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,        1'b1, 32'd4};
        vecs[6]  = '{1'b1, 2'd2, 32'd0,        1'b0, 32'd0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,        1'b1, 32'd4};
        vecs[8]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 1'b0, 32'd0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,        1'b1, 32'd4};
        vecs[10] = '{1'b0, 2'd3, 32'h0,        1'b1, 32'd0};
        vecs[11] = '{1'b1, 2'd2, 32'h00010002, 1'b0, 32'd0};
        vecs[12] = '{1'b0, 2'd2, 32'h0,        1'b1, 32'd2};
        vecs[13] = '{1'b1, 2'd2, 32'd7,        1'b0, 32'd0};
        vecs[14] = '{1'b0, 2'd2, 32'h0,        1'b1, 32'd7};
        vecs[15] = '{1'b1, 2'd2, 32'd4,        1'b0, 32'd0};
        vecs[16] = '{1'b0, 2'd2, 32'h0,        1'b1, 32'd4};
        vecs[17] = '{1'b1, 2'd1, 32'hFFFFFFFF, 1'b0, 32'd0};
        vecs[18] = '{1'b0, 2'd1, 32'h0,        1'b1, 32'h04 | PBIT};

        // Reset state
        repeat (3) tick();
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, tx_busy}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // Register decode and divisor write filtering
        for (int i = 0; i < $size(vecs); i++) begin
            sel = 1'b1; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
            tick();
            sel = 1'b0; we = 1'b0;
            if (vecs[i].chk) check($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // rdata holds across idle cycles and writes
        rd_check(2'd2, 32'd4, "rd_div");
        tick();
        check("rdata_hold_idle", rdata, 32'd4);
        wr(2'd1, 32'd0);
        check("rdata_hold_wr", rdata, 32'd4);

        // Single byte: start latency, bit trace, tx_busy fall time
        rec_q.delete(); exp_q.delete();
        rec_en = 1'b1;
        wr(2'd0, 32'h000000A5);
        tick();
        check("start_latency", {31'b0, tx}, 32'd0);
        ok = 1'b1;
        for (int k = 1; k < NBITS * DIV0; k++) begin
            tick();
            if (tx_busy !== 1'b1) ok = 1'b0;
        end
        check("busy_during_frame", {31'b0, ok}, 32'd1);
        tick();
        check("busy_fall", {31'b0, tx_busy}, 32'd0);
        rec_en = 1'b0;
        add_frame(8'hA5, DIV0, 1'b0);
        compare_trace("frame_a5");

        send_one(8'h07, "frame_07");
        send_one(8'h03, "frame_03");

        // FIFO fill, overflow, overflow clear
        rec_q.delete(); exp_q.delete();
        rec_en = 1'b1;
        for (int b = 1; b <= 6; b++) wr(2'd0, 32'(b));
        rd_check(2'd1, 32'h63 | PBIT, "status_full_ovf");
        wr(2'd1, 32'd0);
        rd_check(2'd1, 32'h23 | PBIT, "status_ovf_clear");
        wait_idle(6 * NBITS * DIV0 + 50, "fifo_idle");
        tick();
        rec_en = 1'b0;
        for (int b = 1; b <= 5; b++) add_frame(8'(b), DIV0, b != 1);
        compare_trace("fifo_frames");

        // A DATA read returns 0 and does not pop
        rec_q.delete(); exp_q.delete();
        rec_en = 1'b1;
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        rd_check(2'd0, 32'd0, "data_read_zero");
        rd_check(2'd1, 32'h09 | PBIT, "status_count1");
        rd_check(2'd0, 32'd0, "data_read_zero2");
        rd_check(2'd1, 32'h09 | PBIT, "status_no_pop");
        wait_idle(3 * NBITS * DIV0 + 50, "nopop_idle");
        tick();
        rec_en = 1'b0;
        add_frame(8'h11, DIV0, 1'b0);
        add_frame(8'h22, DIV0, 1'b1);
        compare_trace("nopop_frames");

        // Divisor change mid-frame only affects the next frame
        rec_q.delete(); exp_q.delete();
        rec_en = 1'b1;
        wr(2'd0, 32'h3C);
        wr(2'd0, 32'hC3);
        wr(2'd2, 32'd8);
        wr(2'd2, 32'd1);
        rd_check(2'd2, 32'd8, "div_after_bad_write");
        wait_idle(NBITS * (DIV0 + 8) + 50, "div_idle");
        tick();
        rec_en = 1'b0;
        add_frame(8'h3C, DIV0, 1'b0);
        add_frame(8'hC3, 8, 1'b1);
        compare_trace("div_change_frames");

        // Reset mid-frame during data bit 3
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h55);
        tick();
        repeat (17) tick();
        check("pre_reset_bit3", {31'b0, tx}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("reset_tx_immediate", {31'b0, tx}, 32'd1);
        check("reset_busy_immediate", {31'b0, tx_busy}, 32'd0);
        check("reset_rdata_immediate", rdata, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        rd_check(2'd1, 32'h04 | PBIT, "status_after_reset");
        ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
        end
        check("no_frame_resume", {31'b0, ok}, 32'd1);
        rd_check(2'd2, 32'd4, "div_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU's peripheral bus; directly downstream of `cpu`.
- Consumes CPU stores to the peripheral window and serialises bytes onto a single TX line (8N1, LSB first).
- Includes a small TX FIFO so the CPU can push several bytes without stalling.
- Exposes a status register the CPU polls.

Parameters:
- CLKS_PER_BIT, 234, reset value of the baud divisor (27 MHz / 115200); clock cycles per UART bit.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2.
- DIV_WIDTH, 16, width of the baud divisor register and bit timer.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- sel  input  1  bus select; a bus access occurs in any cycle with sel=1.
- we  input  1  1 = write, 0 = read; sampled with sel.
- addr  input  2  word register index: 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved.
- wdata  input  32  write data.
- rdata  output  32  read data, registered.
- tx  output  1  UART serial output, idle high.
- tx_busy  output  1  1 while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync-release safe): tx=1, rdata=0, tx_busy=0, FIFO empty, FSM IDLE, divisor=CLKS_PER_BIT, overflow=0. Reset mid-frame aborts the frame immediately; tx returns high the same instant.
- Write DATA: pushes wdata[7:0]; wdata[31:8] ignored.
  - If FIFO full and no pop that cycle: byte dropped, sticky overflow set.
  - If FIFO full and a pop occurs the same cycle: push accepted, count unchanged.
- Write STATUS: any value clears overflow; no other effect.
- Write DIVISOR: loads wdata[DIV_WIDTH-1:0] if value >= 2; otherwise the write is ignored. Each frame samples the divisor when it leaves IDLE, so a mid-frame write affects only later frames.
- Writes to addr 3 are ignored.
- Read: rdata updates on the clock edge after sel=1, we=0 (1-cycle latency); rdata holds its value otherwise.
  - addr 0 → 0.
  - addr 1 → {24'b0, overflow[7]? see layout}. Layout: bit0 tx_busy, bit1 fifo_full, bit2 fifo_empty, bits[5:3] fifo count (saturates at 7), bit6 overflow, bit7 0, bits[31:8] 0.
  - addr 2 → zero-extended divisor.
  - addr 3 → 0.
- FIFO: circular buffer with read/write pointers and a count; wrap-around at FIFO_DEPTH. The FIFO pops when the FSM leaves IDLE.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, latch the divisor, load bit timer = divisor-1, go to START.
  - START: tx=0 for divisor cycles, then DATA with bit index 0.
  - DATA: tx = shift[0] for divisor cycles; shift right; after bit 7 go to STOP.
  - STOP: tx=1 for divisor cycles, then IDLE.
- Timing: a frame occupies exactly 10 × divisor cycles. Back-to-back frames add one IDLE cycle between the stop bit and the next start bit.
- Latency: DATA write in cycle N, FIFO previously empty and FSM in IDLE → tx falls at the edge ending cycle N+1.
- tx_busy = (state != IDLE) | ~fifo_empty; registered with the state update.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP that drives even parity (XOR of the 8 data bits) for divisor cycles. Frame becomes 11 × divisor cycles. STATUS bit7 reads 1 to report parity support.
- Undefined: 8N1 only; STATUS bit7 reads 0; no PARITY state is synthesised.

Test Plan:
- Reset mid-frame: CLKS_PER_BIT=4, write 0x55, assert reset_n=0 during DATA bit 3 → tx=1 immediately; after release STATUS reads 0x04 and no frame resumes.
- Single byte: CLKS_PER_BIT=4, write DATA=0xA5 → tx sequence 0 (start), then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; tx_busy falls 40 cycles after the start edge.
- FIFO fill and overflow: with the line stalled in the first frame, write 0x01..0x06 → STATUS shows fifo_full=1, count=4, overflow=1. Only 0x01..0x05 are transmitted, since 0x01 was popped first and freed an entry. Writing STATUS then clears bit6.
- Divisor change: write DIVISOR=8 while frame 1 (divisor 4) is on the line → frame 1 uses 4-cycle bits, frame 2 uses 8-cycle bits. Writing DIVISOR=1 is ignored and a DIVISOR read returns 8.
- Read latency and decode: read addr 2 after reset → rdata=CLKS_PER_BIT on the next cycle. Read addr 3 → 0. A DATA read does not pop the FIFO.
- Parity build (UART_TX_PARITY_EN): send 0x07 → parity bit 1 before stop; send 0x03 → parity bit 0; frame length 44 cycles at divisor 4.
